border_projection: RTL

BORDER_PROJECTION -- requirements
Module: border_projection

---
 rtl/border_projection_pkg.sv | 29 ++
 rtl/border_projection_edge_border_extractor.sv | 107 ++++++++++
 rtl/border_projection.sv | 125 ++++++++++++
 3 files changed

// File: rtl/border_projection_pkg.sv
// Shared definitions for the border projection block.
//   - image size defaults, border/address width
//   - frame phase encoding driven out on frame_cnt
//   - border RAM address convention: even = left/top, odd = right/bottom
package border_projection_pkg;

  localparam int unsigned H_PIXEL_DEF = 480;
  localparam int unsigned V_PIXEL_DEF = 272;
  localparam int unsigned BORDER_W    = 11;

  typedef logic [BORDER_W-1:0] border_t;

  typedef enum logic [1:0] {
    FRM_PROJECT = 2'd0,
    FRM_EXTRACT = 2'd1,
    FRM_DONE    = 2'd2
  } frame_e;

  // Address LSB selects which side of border k an entry holds.
  typedef enum logic {
    EDGE_OPEN  = 1'b0,
    EDGE_CLOSE = 1'b1
  } edge_side_e;

  function automatic border_t border_addr(input logic [3:0] k, input edge_side_e side);
    return {{(BORDER_W-5){1'b0}}, k, (side == EDGE_CLOSE)};
  endfunction

endpackage

// File: rtl/border_projection_edge_border_extractor.sv
// Edge detector, border counter and border RAM for one projection axis.
//   clear_i   : start of extraction frame, empties RAM and counter
//   scan_i    : current pixel is a scan point for this axis
//   pos_i     : scan position (xpos or ypos)
//   flag_i    : projection flag at pos_i
//   rd_addr_i / rd_data_o : registered read port, 0 for unwritten/out of range
//   num_o     : number of closed borders (saturates at NUM)
module edge_border_extractor
  import border_projection_pkg::*;
#(
  parameter int unsigned LEN = H_PIXEL_DEF,
  parameter int unsigned NUM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          scan_i,
  input  logic [10:0]   pos_i,
  input  logic          flag_i,
  input  logic [10:0]   rd_addr_i,
  output logic [10:0]   rd_data_o,
  output logic [3:0]    num_o
);

  localparam int unsigned DEPTH = 2 * NUM;
  localparam border_t     LAST  = border_t'(LEN - 1);

  logic [3:0] k_q, k_d;
  logic       prev_q, prev_d;
  logic       open_we_q, open_we_d, close_we_q, close_we_d;
  border_t    open_addr_q, open_addr_d, open_data_q, open_data_d;
  border_t    close_addr_q, close_addr_d, close_data_q, close_data_d;
  border_t    ram_q [DEPTH];
  border_t    rd_data_q, rd_data_d;

  logic prev_eff, rise, fall, at_end, room;

  always_comb begin
    // Position 0 starts a fresh scan, so nothing is open before it.
    prev_eff = (pos_i == '0) ? 1'b0 : prev_q;
    rise     = scan_i & flag_i & ~prev_eff;
    fall     = scan_i & ~flag_i & prev_eff;
    at_end   = scan_i & flag_i & (pos_i == LAST);
    room     = (32'(k_q) < NUM);

    k_d          = k_q;
    prev_d       = scan_i ? flag_i : prev_q;
    open_we_d    = rise & room;
    open_addr_d  = border_addr(k_q, EDGE_OPEN);
    open_data_d  = pos_i;
    // A border open at the last position closes there; a one-pixel border
    // at the last position fires both writes in the same cycle.
    close_we_d   = (fall | at_end) & room;
    close_addr_d = border_addr(k_q, EDGE_CLOSE);
    close_data_d = fall ? (pos_i - 11'd1) : LAST;
    if (close_we_d) k_d = k_q + 4'd1;

    if (clear_i) begin
      k_d        = '0;
      prev_d     = 1'b0;
      open_we_d  = 1'b0;
      close_we_d = 1'b0;
    end

    rd_data_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == border_t'(i)) rd_data_d = ram_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      prev_q       <= 1'b0;
      open_we_q    <= 1'b0;
      close_we_q   <= 1'b0;
      open_addr_q  <= '0;
      open_data_q  <= '0;
      close_addr_q <= '0;
      close_data_q <= '0;
      rd_data_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else begin
      k_q          <= k_d;
      prev_q       <= prev_d;
      open_we_q    <= open_we_d;
      close_we_q   <= close_we_d;
      open_addr_q  <= open_addr_d;
      open_data_q  <= open_data_d;
      close_addr_q <= close_addr_d;
      close_data_q <= close_data_d;
      rd_data_q    <= rd_data_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (clear_i) begin
          ram_q[i] <= '0;
        end else begin
          if (open_we_q  && open_addr_q  == border_t'(i)) ram_q[i] <= open_data_q;
          if (close_we_q && close_addr_q == border_t'(i)) ram_q[i] <= close_data_q;
        end
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign num_o     = k_q;

endmodule

// File: rtl/border_projection.sv
// Digit border projection over a 3-frame cycle.
//   frame 0: project foreground pixels onto column/row flag arrays
//   frame 1: scan flags, record left/right and top/bottom borders
//   frame 2: results stable, project_done_flag high
// Ports: clk, rst_n (async low), frame_vsync, monoc (0 = foreground),
//   xpos/ypos pixel position, row/col border read ports (1-clk latency),
//   frame_cnt, project_done_flag, num_col, num_row.
module border_projection
  import border_projection_pkg::*;
#(
  parameter int unsigned H_PIXEL = H_PIXEL_DEF,
  parameter int unsigned V_PIXEL = V_PIXEL_DEF,
  parameter int unsigned NUM_ROW = 1,
  parameter int unsigned NUM_COL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic        monoc,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [10:0] row_border_addr,
  output logic [10:0] row_border_data,
  input  logic [10:0] col_border_addr,
  output logic [10:0] col_border_data,
  output logic [1:0]  frame_cnt,
  output logic        project_done_flag,
  output logic [3:0]  num_col,
  output logic [3:0]  num_row
);

  localparam border_t     H_LIM = border_t'(H_PIXEL);
  localparam border_t     V_LIM = border_t'(V_PIXEL);
  localparam int unsigned XW    = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
  localparam int unsigned YW    = (V_PIXEL > 1) ? $clog2(V_PIXEL) : 1;

  logic               vsync_q;
  frame_e             frame_q, frame_d;
  logic               done_q, done_d;
  logic [H_PIXEL-1:0] col_flag_q, col_flag_d;
  logic [V_PIXEL-1:0] row_flag_q, row_flag_d;

  logic vs_rise, in_range, clear_scan, col_scan, row_scan;

  assign vs_rise    = frame_vsync & ~vsync_q;
  assign in_range   = (xpos < H_LIM) && (ypos < V_LIM);
  assign clear_scan = vs_rise && (frame_q == FRM_PROJECT);
  assign col_scan   = (frame_q == FRM_EXTRACT) && in_range && (ypos == '0);
  assign row_scan   = (frame_q == FRM_EXTRACT) && in_range && (xpos == '0);

  always_comb begin
    frame_d    = frame_q;
    done_d     = done_q;
    col_flag_d = col_flag_q;
    row_flag_d = row_flag_q;
    if (vs_rise) begin
      unique case (frame_q)
        FRM_PROJECT: frame_d = FRM_EXTRACT;
        FRM_EXTRACT: begin
          frame_d = FRM_DONE;
          done_d  = 1'b1;
        end
        default: begin
          frame_d    = FRM_PROJECT;
          done_d     = 1'b0;
          col_flag_d = '0;
          row_flag_d = '0;
        end
      endcase
    end else if (frame_q == FRM_PROJECT && in_range && !monoc) begin
      col_flag_d[xpos[XW-1:0]] = 1'b1;
      row_flag_d[ypos[YW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      frame_q    <= FRM_PROJECT;
      done_q     <= 1'b0;
      col_flag_q <= '0;
      row_flag_q <= '0;
    end else begin
      vsync_q    <= frame_vsync;
      frame_q    <= frame_d;
      done_q     <= done_d;
      col_flag_q <= col_flag_d;
      row_flag_q <= row_flag_d;
    end
  end

  edge_border_extractor #(
    .LEN (H_PIXEL),
    .NUM (NUM_COL)
  ) u_col_border (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_scan),
    .scan_i    (col_scan),
    .pos_i     (xpos),
    .flag_i    (col_flag_q[xpos[XW-1:0]]),
    .rd_addr_i (col_border_addr),
    .rd_data_o (col_border_data),
    .num_o     (num_col)
  );

  edge_border_extractor #(
    .LEN (V_PIXEL),
    .NUM (NUM_ROW)
  ) u_row_border (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_scan),
    .scan_i    (row_scan),
    .pos_i     (ypos),
    .flag_i    (row_flag_q[ypos[YW-1:0]]),
    .rd_addr_i (row_border_addr),
    .rd_data_o (row_border_data),
    .num_o     (num_row)
  );

  assign frame_cnt         = frame_q;
  assign project_done_flag = done_q;

endmodule
